// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_arbiter
// Purpose  : Shares the byte-lane data RAM between the CPU load/store unit
//            (priority) and the word-oriented debug port. It also builds lane
//            enables, aligns load data and forwards same-cycle writes.
// Revision : 1.0  initial release
// ============================================================================
module dram_arbiter #(
    parameter int DWIDTH     = 12,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_adr,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_misalign,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [DWIDTH-1:0] dbg_adr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_rvalid,
    output logic [DWIDTH-1:0] ram_radr,
    output logic [DWIDTH-1:0] ram_wadr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wen,
    input  logic [31:0]       ram_rdata
);

    localparam int         c_WCW   = $clog2(STARVE_MAX + 1);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PEND  = 2'd1;
    localparam logic [1:0] c_RDRET = 2'd2;

    logic [1:0]        r_state;
    logic [c_WCW-1:0]  r_wait_cnt;
    logic [3:0]        r_fwd_wen;
    logic [31:0]       r_fwd_wdata;
    logic              r_ld_valid;
    logic [1:0]        r_ld_off;
    logic [1:0]        r_ld_size;
    logic              r_ld_uns;
    logic [31:0]       r_dbg_rdata;

    logic              w_port_free;
    logic              w_dbg_grant;
    logic              w_dbg_rd;
    logic              w_dbg_wr;
    logic              w_cpu_rd;
    logic              w_cpu_wr;
    logic [DWIDTH-1:0] w_cpu_word;
    logic [3:0]        w_cpu_wen;
    logic [31:0]       w_cpu_wdata;
    logic              w_collide;
    logic [31:0]       w_merged;
    logic [31:0]       w_load;
    logic              w_unused_adr;

    assign w_unused_adr = ^cpu_adr[31:DWIDTH+2];
    assign w_cpu_word   = cpu_adr[DWIDTH+1:2];

    assign cpu_misalign = ((cpu_size == 2'd1) && cpu_adr[0]) ||
                          ((cpu_size >= 2'd2) && (cpu_adr[1:0] != 2'b00));

    // The forced stall is a one-cycle hole that lets a starved debug request in.
    assign cpu_stall = !rst && (r_state == c_PEND) && dbg_req &&
                       (r_wait_cnt == c_WCW'(STARVE_MAX));

    assign w_port_free = dbg_we ? (!cpu_we || cpu_stall) : (!cpu_re || cpu_stall);
    assign w_dbg_grant = !rst && dbg_req && (r_state != c_RDRET) && w_port_free;
    assign w_dbg_rd    = w_dbg_grant && !dbg_we;
    assign w_dbg_wr    = w_dbg_grant && dbg_we;
    assign dbg_ack     = w_dbg_grant;

    assign w_cpu_rd = !rst && cpu_re && !cpu_stall && !cpu_misalign;
    assign w_cpu_wr = !rst && cpu_we && !cpu_stall && !cpu_misalign;

    always_comb begin
        w_cpu_wen   = 4'b1111;
        w_cpu_wdata = cpu_wdata;
        case (cpu_size)
            2'd0: begin
                w_cpu_wen   = 4'b0001 << cpu_adr[1:0];
                w_cpu_wdata = {4{cpu_wdata[7:0]}};
            end
            2'd1: begin
                w_cpu_wen   = 4'b0011 << cpu_adr[1:0];
                w_cpu_wdata = {2{cpu_wdata[15:0]}};
            end
            default: begin
                w_cpu_wen   = 4'b1111;
                w_cpu_wdata = cpu_wdata;
            end
        endcase
    end

    assign ram_radr  = w_dbg_rd ? dbg_adr : w_cpu_word;
    assign ram_wadr  = w_dbg_wr ? dbg_adr : w_cpu_word;
    assign ram_wdata = w_dbg_wr ? dbg_wdata : w_cpu_wdata;
    assign ram_wen   = w_dbg_wr ? 4'b1111 : (w_cpu_wr ? w_cpu_wen : 4'b0000);

    // The RAM returns pre-write data on a same-word collision; patch it next cycle.
    assign w_collide = (w_dbg_rd || w_cpu_rd) && (ram_wen != 4'b0000) &&
                       (ram_radr == ram_wadr);

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign w_merged[8*i +: 8] = r_fwd_wen[i] ? r_fwd_wdata[8*i +: 8]
                                                     : ram_rdata[8*i +: 8];
        end
    endgenerate

    always_comb begin
        w_load = w_merged;
        case (r_ld_size)
            2'd0: begin
                case (r_ld_off)
                    2'd0:    w_load[7:0] = w_merged[7:0];
                    2'd1:    w_load[7:0] = w_merged[15:8];
                    2'd2:    w_load[7:0] = w_merged[23:16];
                    default: w_load[7:0] = w_merged[31:24];
                endcase
                w_load[31:8] = {24{w_load[7] && !r_ld_uns}};
            end
            2'd1: begin
                w_load[15:0]  = r_ld_off[1] ? w_merged[31:16] : w_merged[15:0];
                w_load[31:16] = {16{w_load[15] && !r_ld_uns}};
            end
            default: w_load = w_merged;
        endcase
    end

    assign cpu_rdata  = r_ld_valid ? w_load : 32'd0;
    assign dbg_rvalid = !rst && (r_state == c_RDRET);
    assign dbg_rdata  = dbg_rvalid ? w_merged : r_dbg_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_wait_cnt  <= '0;
            r_fwd_wen   <= 4'b0000;
            r_fwd_wdata <= 32'd0;
            r_ld_valid  <= 1'b0;
            r_ld_off    <= 2'd0;
            r_ld_size   <= 2'd0;
            r_ld_uns    <= 1'b0;
            r_dbg_rdata <= 32'd0;
        end else begin
            r_fwd_wen   <= w_collide ? ram_wen : 4'b0000;
            r_fwd_wdata <= w_collide ? ram_wdata : 32'd0;
            r_ld_valid  <= w_cpu_rd;
            r_ld_off    <= cpu_adr[1:0];
            r_ld_size   <= cpu_size;
            r_ld_uns    <= cpu_unsigned;
            case (r_state)
                c_IDLE: begin
                    if (w_dbg_grant) begin
                        r_state    <= dbg_we ? c_IDLE : c_RDRET;
                        r_wait_cnt <= '0;
                    end else if (dbg_req) begin
                        r_state    <= c_PEND;
                        r_wait_cnt <= c_WCW'(1);
                    end
                end
                c_PEND: begin
                    if (!dbg_req) begin
                        r_state    <= c_IDLE;
                        r_wait_cnt <= '0;
                    end else if (w_dbg_grant) begin
                        r_state    <= dbg_we ? c_IDLE : c_RDRET;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WCW'(1);
                    end
                end
                c_RDRET: begin
                    r_dbg_rdata <= w_merged;
                    if (dbg_req) begin
                        r_state    <= c_PEND;
                        r_wait_cnt <= c_WCW'(1);
                    end else begin
                        r_state    <= c_IDLE;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_arbiter
// Purpose  : Directed self-checking bench for dram_arbiter with a RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dram_arbiter;

    localparam int c_DW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_re, cpu_we, cpu_unsigned;
    logic [31:0]       cpu_adr, cpu_wdata, cpu_rdata;
    logic [1:0]        cpu_size;
    logic              cpu_misalign, cpu_stall;
    logic              dbg_req, dbg_we, dbg_ack, dbg_rvalid;
    logic [c_DW-1:0]   dbg_adr;
    logic [31:0]       dbg_wdata, dbg_rdata;
    logic [c_DW-1:0]   ram_radr, ram_wadr;
    logic [31:0]       ram_wdata, ram_rdata;
    logic [3:0]        ram_wen;

    logic [31:0]       mem [0:(1<<c_DW)-1];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                ack_at, early;

    always #5 clk = ~clk;

    dram_arbiter #(.DWIDTH(c_DW), .STARVE_MAX(15)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_size(cpu_size),
        .cpu_unsigned(cpu_unsigned), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_misalign(cpu_misalign), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .ram_radr(ram_radr), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata),
        .ram_wen(ram_wen), .ram_rdata(ram_rdata)
    );

    // Registered-address RAM: read returns pre-write contents on a collision.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_radr];
        for (int i = 0; i < 4; i++)
            if (ram_wen[i]) mem[ram_wadr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic re, input logic we, input logic [31:0] adr,
                           input logic [1:0] size, input logic uns, input logic [31:0] wd);
        cpu_re = re; cpu_we = we; cpu_adr = adr;
        cpu_size = size; cpu_unsigned = uns; cpu_wdata = wd;
    endtask

    // CPU loads every cycle while a debug read is held; report the ack cycle.
    task automatic run_starve(output int at, output int stalls_before);
        at = -1;
        stalls_before = 0;
        cpu_set(1'b1, 1'b0, 32'h102, 2'd0, 1'b1, 32'd0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 12'd5;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (dbg_ack) begin
                at = i;
                break;
            end
            if (cpu_stall) stalls_before++;
            cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << c_DW); i++) mem[i] = 32'd0;
        rst = 1'b1;
        cpu_set(1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_adr = '0; dbg_wdata = 32'd0;
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'd0);
        check("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
        check("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_ram_wen", {28'd0, ram_wen}, 32'd0);

        // SB 0xA5 to 0x102, then LB / LBU
        cyc();
        cpu_set(1'b0, 1'b1, 32'h102, 2'd0, 1'b0, 32'h000000A5);
        #1;
        check("sb_wen", {28'd0, ram_wen}, 32'h4);
        check("sb_wadr", {20'd0, ram_wadr}, 32'h40);
        check("sb_wdata", ram_wdata, 32'hA5A5A5A5);
        cyc();
        check("sb_mem", mem[12'h40], 32'h00A50000);
        cpu_set(1'b1, 1'b0, 32'h102, 2'd0, 1'b0, 32'd0);
        #1;
        check("lb_radr", {20'd0, ram_radr}, 32'h40);
        cyc();
        check("lb_data", cpu_rdata, 32'hFFFFFFA5);
        cpu_unsigned = 1'b1;
        cyc();
        check("lbu_data", cpu_rdata, 32'h000000A5);

        // Misaligned SH, aligned SH then LH, misaligned LW
        cpu_set(1'b0, 1'b1, 32'h13, 2'd1, 1'b0, 32'h1234);
        #1;
        check("sh_mis_flag", {31'd0, cpu_misalign}, 32'd1);
        check("sh_mis_wen", {28'd0, ram_wen}, 32'd0);
        cyc();
        check("sh_mis_mem", mem[12'h4], 32'd0);
        cpu_set(1'b0, 1'b1, 32'h12, 2'd1, 1'b0, 32'h8001);
        #1;
        check("sh_wen", {28'd0, ram_wen}, 32'hC);
        check("sh_wdata", ram_wdata, 32'h80018001);
        cyc();
        cpu_set(1'b1, 1'b0, 32'h12, 2'd1, 1'b0, 32'd0);
        cyc();
        check("lh_data", cpu_rdata, 32'hFFFF8001);
        cpu_set(1'b1, 1'b0, 32'h13, 2'd2, 1'b0, 32'd0);
        #1;
        check("lw_mis_flag", {31'd0, cpu_misalign}, 32'd1);
        cyc();
        check("lw_mis_data", cpu_rdata, 32'd0);

        // SW + LW same word, same cycle
        cpu_set(1'b1, 1'b1, 32'h200, 2'd2, 1'b0, 32'hDEADBEEF);
        cyc();
        cpu_set(1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        check("fwd_cpu", cpu_rdata, 32'hDEADBEEF);

        // Debug write then read of word 5, CPU idle
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 12'd5; dbg_wdata = 32'h11223344;
        #1;
        check("dw_ack", {31'd0, dbg_ack}, 32'd1);
        check("dw_wen", {28'd0, ram_wen}, 32'hF);
        cyc();
        dbg_we = 1'b0;
        #1;
        check("dr_ack", {31'd0, dbg_ack}, 32'd1);
        check("dr_radr", {20'd0, ram_radr}, 32'd5);
        cyc();
        dbg_req = 1'b0;
        #1;
        check("dr_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check("dr_data", dbg_rdata, 32'h11223344);
        cyc();

        // Debug read of word 5 alongside a CPU SB to lane 0 of word 5
        dbg_req = 1'b1;
        cpu_set(1'b0, 1'b1, 32'h14, 2'd0, 1'b0, 32'h77);
        #1;
        check("drw_ack", {31'd0, dbg_ack}, 32'd1);
        cyc();
        dbg_req = 1'b0;
        cpu_set(1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        #1;
        check("drw_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check("drw_data", dbg_rdata, 32'h11223377);
        cyc();
        check("drw_rvalid_low", {31'd0, dbg_rvalid}, 32'd0);
        check("drw_hold", dbg_rdata, 32'h11223377);

        // Starvation: forced stall at wait count 15
        run_starve(ack_at, early);
        check("stv_ack_cycle", ack_at, 32'd15);
        check("stv_no_early", early, 32'd0);
        check("stv_stall", {31'd0, cpu_stall}, 32'd1);
        check("stv_radr", {20'd0, ram_radr}, 32'd5);
        cyc();
        dbg_req = 1'b0;
        #1;
        check("stv_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check("stv_data", dbg_rdata, 32'h11223377);
        check("stv_stall_drop", {31'd0, cpu_stall}, 32'd0);
        check("stv_stalled_ld", cpu_rdata, 32'd0);
        cyc();
        check("stv_reload", cpu_rdata, 32'h000000A5);

        // Reset while pending at wait count 7
        dbg_req = 1'b1; dbg_we = 1'b0;
        repeat (7) cyc();
        rst = 1'b1;
        #1;
        check("rstp_ack", {31'd0, dbg_ack}, 32'd0);
        cyc();
        rst = 1'b0; dbg_req = 1'b0;
        cpu_set(1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        #1;
        check("rstp_cpu_rdata", cpu_rdata, 32'd0);
        check("rstp_dbg_rdata", dbg_rdata, 32'd0);
        check("rstp_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        check("rstp_stall", {31'd0, cpu_stall}, 32'd0);
        check("rstp_wen", {28'd0, ram_wen}, 32'd0);
        cyc();
        run_starve(ack_at, early);
        check("rstp_restart", ack_at, 32'd15);
        cyc();
        dbg_req = 1'b0;
        cpu_set(1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
